// File: rtl/fetch_unit.sv
// Instruction fetch and next-PC stage of the multicycle core.
// Fetches one word per instruction, then resolves the branch code into the next pc.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  input  logic [3:0]  branch,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        stall,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        bad_branch
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC
  } state_t;

  state_t state, state_nx;

  logic [31:0] pc_q, ir_q;
  logic [31:0] pc4, btgt, jtgt, next_pc;
  logic signed [31:0] rs_s, rt_s;
  logic adv;

  assign pc4  = pc_q + 32'd4;
  assign btgt = pc4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign jtgt = {pc4[31:28], ir_q[25:0], 2'b00};
  assign rs_s = rs_val;
  assign rt_s = rt_val;

  always_comb begin
    next_pc = pc4;
    case (branch)
      4'b0001: next_pc = jtgt;
      4'b1011: next_pc = jtgt;
      4'b0010: next_pc = {rs_val[31:2], 2'b00};
      4'b0011: next_pc = (rs_s == rt_s) ? btgt : pc4;
      4'b0100: next_pc = (rs_s != rt_s) ? btgt : pc4;
      4'b0101: next_pc = (rs_s <= 0) ? btgt : pc4;
      4'b0110: next_pc = (rs_s > 0) ? btgt : pc4;
      4'b0111: next_pc = (rs_s < rt_s) ? btgt : pc4;
      4'b1000: next_pc = (rs_s > rt_s) ? btgt : pc4;
      4'b1001: next_pc = (rs_s >= rt_s) ? btgt : pc4;
      4'b1010: next_pc = (rs_s <= rt_s) ? btgt : pc4;
      default: next_pc = pc4;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   state_nx = FETCH;
      FETCH:  if (imem_ready) state_nx = DECODE;
      DECODE: state_nx = EXEC;
      EXEC:   if (!stall) state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes come straight from state so reset kills them at once.
  assign imem_req   = (state == FETCH);
  assign adv        = (state == EXEC) && !stall;
  assign link_we    = adv && (branch == 4'b1011);
  assign bad_branch = adv && (branch[3:2] == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= RESET_PC;
      ir_q  <= '0;
    end else begin
      state <= state_nx;
      if (imem_req && imem_ready) ir_q <= imem_rdata;
      if (adv) pc_q <= next_pc;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[31:26];
  assign link_addr = pc4;

endmodule
